datamem_responder: RTL and testbench

- Memory-side responder for the CPU's data-memory port: accepts one load/store request at a time over a valid/ready handshake, then returns a response after a programmable wait-state latency.
- Replaces the zero-latency data memory so the multi-cycle CPU can be exercised against realistic memory timing.
- Word-organised storage; byte enables apply to stores; misaligned and out-of-range accesses return an error and leave storage untouched.

---
 rtl/datamem_pkg.sv | 23 ++
 rtl/datamem_responder_if.sv | 24 ++
 rtl/dm_wordram.sv | 39 +++
 rtl/datamem_responder.sv | 144 ++++++++++++++
 tb/tb_datamem_responder.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/datamem_pkg.sv
// Shared encodings and the access-legality helper for the data-memory responder.
// Pure definitions: no latency and no flow control live here.
package datamem_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int WORD_BYTES = 4;

    localparam logic ERR_NONE   = 1'b0;
    localparam logic ERR_ACCESS = 1'b1;

    // Upper address bits are not masked, so a high alias is reported as out of range.
    function automatic logic access_err(input logic [31:0] addr, input int unsigned depth);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[1:0] != 2'b00);
        out_of_range = ({2'b00, addr[31:2]} >= depth);
        return (misaligned || out_of_range) ? ERR_ACCESS : ERR_NONE;
    endfunction

endpackage

// File: rtl/datamem_responder_if.sv
// Request/response bundle between the CPU data port (master) and the responder (slave).
// Both phases use valid/ready; the responder never accepts while a response is pending.
interface datamem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        resp_ready;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_wordram.sv
// Single-port word RAM with per-byte write enables; read data is registered (1 cycle).
// No flow control: the caller pulses en once per access and holds nothing afterwards.
module dm_wordram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // Read-before-write: a store returns the old word, which the responder discards.
    always_comb begin
        rdata_d = rdata_q;
        if (en) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (en && we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/datamem_responder.sv
// Data-memory responder: one outstanding load/store, response LATENCY+1 cycles after accept.
// Response holds under resp_ready backpressure; req_ready stays low until the handoff edge.
module datamem_responder
    import datamem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    datamem_responder_if.slave   bus
);
    localparam int AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int OFFS = $clog2(WORD_BYTES);
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        err_q, err_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic        accept;
    logic        commit;
    logic        in_idle;
    logic        c_write;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_be;
    logic        c_err;
    logic [31:0] ram_rdata;

    assign bus.req_ready  = reset && (state_q == ST_IDLE);
    assign accept         = bus.req_valid && bus.req_ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    // With zero wait states the commit shares the accept edge, so it takes the live request.
    always_comb begin
        in_idle = (state_q == ST_IDLE);
        c_write = in_idle ? bus.req_write : write_q;
        c_addr  = in_idle ? bus.req_addr  : addr_q;
        c_wdata = in_idle ? bus.req_wdata : wdata_q;
        c_be    = in_idle ? bus.req_be    : be_q;
        c_err   = access_err(c_addr, DEPTH_WORDS);
        commit  = reset && ((accept && (LATENCY == 0)) ||
                            ((state_q == ST_WAIT) && (cnt_q == 4'd0)));
    end

    dm_wordram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .en    (commit),
        .we    (c_write && (c_err == ERR_NONE)),
        .be    (c_be),
        .addr  (c_addr[OFFS +: AW]),
        .wdata (c_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        err_d        = err_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                        err_d   = c_err;
                    end else begin
                        cnt_d   = LAT_M1;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    err_d   = c_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                // First RESP cycle lets the registered RAM read settle before presenting it.
                if (!resp_valid_q) begin
                    resp_valid_d = 1'b1;
                    resp_err_d   = err_q;
                    resp_rdata_d = (write_q || err_q) ? 32'd0 : ram_rdata;
                end else if (bus.resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = 32'd0;
                    resp_err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        write_q <= write_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        be_q    <= be_d;
        err_q   <= err_d;
    end
endmodule

// File: tb/tb_datamem_responder.sv
// Directed bench: default build (LATENCY=2) plus a zero-wait-state build sharing clk/reset.
module tb_datamem_responder;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    datamem_responder_if bus ();
    datamem_responder_if bus0 ();

    datamem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    datamem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one transaction on the LATENCY=2 instance; hold = cycles of resp_ready backpressure.
    task automatic do_txn(input string tag, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be, input int hold,
                          input logic early, input logic [31:0] exp_rdata, input logic exp_err);
        int g;
        int lat;
        logic [31:0] rd;
        logic er;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_be    = be;
        g = 0;
        while (!bus.req_ready && g < 20) begin
            step();
            g++;
        end
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        step();
        bus.req_valid = 1'b0;
        if (early) bus.resp_ready = 1'b1;
        lat = 0;
        while (!bus.resp_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd3);
        rd = bus.resp_rdata;
        er = bus.resp_err;
        check({tag, "_rdata"}, rd, exp_rdata);
        check({tag, "_err"}, 32'(er), 32'(exp_err));
        for (int h = 0; h < hold; h++) begin
            step();
            check({tag, "_hold_vld"}, 32'(bus.resp_valid), 32'd1);
            check({tag, "_hold_rdata"}, bus.resp_rdata, rd);
            check({tag, "_hold_err"}, 32'(bus.resp_err), 32'(er));
            check({tag, "_hold_rdy"}, 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        step();
        bus.resp_ready = 1'b0;
        check({tag, "_post_vld"}, 32'(bus.resp_valid), 32'd0);
        check({tag, "_post_rdy"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        int acc_cyc[$];
        int vld_cyc[$];
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        bus.req_valid = 1'b0;  bus.req_write = 1'b0;  bus.req_addr = 32'd0;
        bus.req_wdata = 32'd0; bus.req_be = 4'h0;     bus.resp_ready = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = 32'd0;
        bus0.req_wdata = 32'd0; bus0.req_be = 4'h0;   bus0.resp_ready = 1'b0;

        repeat (3) step();
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        reset = 1'b1;
        #1;
        check("rel_req_ready", 32'(bus.req_ready), 32'd1);

        do_txn("init0",  1'b1, 32'h0000_0000, 32'h0123_4567, 4'hF, 0, 1'b0, 32'd0, 1'b0);
        do_txn("init20", 1'b1, 32'h0000_0020, 32'hA5A5_A5A5, 4'hF, 0, 1'b0, 32'd0, 1'b0);
        do_txn("st10",   1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'd0, 1'b0);
        do_txn("ld10",   1'b0, 32'h0000_0010, 32'd0,         4'h0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0);
        do_txn("stbe",   1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101, 0, 1'b0, 32'd0, 1'b0);
        do_txn("ldbe",   1'b0, 32'h0000_0010, 32'd0,         4'hF, 0, 1'b1, 32'hDE22_BE44, 1'b0);
        do_txn("stbe0",  1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 0, 1'b0, 32'd0, 1'b0);
        do_txn("ldbe0",  1'b0, 32'h0000_0010, 32'd0,         4'h0, 0, 1'b0, 32'hDE22_BE44, 1'b0);
        do_txn("ldmis",  1'b0, 32'h0000_0012, 32'd0,         4'hF, 0, 1'b0, 32'd0, 1'b1);
        do_txn("stoor",  1'b1, 32'h0000_1000, 32'hBAD0_BAD0, 4'hF, 0, 1'b0, 32'd0, 1'b1);
        do_txn("ld0",    1'b0, 32'h0000_0000, 32'd0,         4'h0, 0, 1'b0, 32'h0123_4567, 1'b0);
        do_txn("ldhi",   1'b0, 32'h8000_0010, 32'd0,         4'h0, 0, 1'b0, 32'd0, 1'b1);
        do_txn("stlast", 1'b1, 32'h0000_0FFC, 32'h5A5A_0FFC, 4'hF, 0, 1'b0, 32'd0, 1'b0);
        do_txn("ldlast", 1'b0, 32'h0000_0FFC, 32'd0,         4'h0, 0, 1'b0, 32'h5A5A_0FFC, 1'b0);
        do_txn("bp",     1'b0, 32'h0000_0010, 32'd0,         4'h0, 5, 1'b0, 32'hDE22_BE44, 1'b0);

        // Abort a store while it is waiting.
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h0000_0020;
        bus.req_wdata = 32'hFFFF_0000; bus.req_be = 4'hF;
        step();
        bus.req_valid = 1'b0;
        reset = 1'b0;
        step();
        check("mrst_vld", 32'(bus.resp_valid), 32'd0);
        check("mrst_rdata", bus.resp_rdata, 32'd0);
        check("mrst_err", 32'(bus.resp_err), 32'd0);
        check("mrst_rdy", 32'(bus.req_ready), 32'd0);
        reset = 1'b1;
        repeat (4) step();
        check("mrst_novld", 32'(bus.resp_valid), 32'd0);
        do_txn("ld20", 1'b0, 32'h0000_0020, 32'd0, 4'h0, 0, 1'b0, 32'hA5A5_A5A5, 1'b0);

        // Zero-wait-state build: store then load, requests held continuously.
        bus0.req_valid = 1'b1; bus0.req_write = 1'b1; bus0.req_addr = 32'h0000_0040;
        bus0.req_wdata = 32'hCAFE_F00D; bus0.req_be = 4'hF; bus0.resp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (bus0.req_ready) acc_cyc.push_back(c);
            step();
            if (bus0.resp_valid) begin
                vld_cyc.push_back(c);
                if (vld_cyc.size() == 1) check("l0_st_rdata", bus0.resp_rdata, 32'd0);
                if (vld_cyc.size() == 2) check("l0_ld_rdata", bus0.resp_rdata, 32'hCAFE_F00D);
                if (vld_cyc.size() == 2) check("l0_ld_err", 32'(bus0.resp_err), 32'd0);
            end
            if (acc_cyc.size() >= 1) bus0.req_write = 1'b0;
        end
        bus0.req_valid = 1'b0;
        bus0.resp_ready = 1'b0;
        check("l0_n_acc", 32'(acc_cyc.size()), 32'd4);
        check("l0_n_vld", 32'(vld_cyc.size()), 32'd4);
        if (acc_cyc.size() == 4 && vld_cyc.size() == 4) begin
            check("l0_lat", 32'(vld_cyc[0] - acc_cyc[0]), 32'd1);
            check("l0_sp1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            check("l0_sp2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
            check("l0_sp3", 32'(acc_cyc[3] - acc_cyc[2]), 32'd3);
            check("l0_lat3", 32'(vld_cyc[3] - acc_cyc[3]), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
